contador_seq: RTL

// - Upstream command sequencer for the 4-bit up/down counter (74x193-style pins MR, PL, CPU, CPD, P0-P3).
// - Accepts CLEAR / LOAD / UP n / DOWN n commands over a valid/ready handshake.
// - Converts each command into a correctly ordered, clock-synchronous pin waveform.
// - Keeps a shadow of the expected count and reports terminal-count (TCU/TCD) events back to the system.

---
 rtl/contador_pkg.sv | 29 ++
 rtl/contador_tc_sync.sv | 32 +++
 rtl/contador_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared types for the 74x193 command sequencer: opcodes, FSM states and widths.
package contador_pkg;

    localparam int CNT_W = 4;
    localparam int REP_W = 5;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_LOAD_SETUP = 3'd2,
        ST_LOAD_ACT   = 3'd3,
        ST_LOAD_HOLD  = 3'd4,
        ST_PULSE_LO   = 3'd5,
        ST_PULSE_HI   = 3'd6
    } seq_state_e;

    // A pulse count of zero encodes a full wrap of sixteen pulses.
    function automatic logic [REP_W-1:0] pulse_count(input logic [CNT_W-1:0] n);
        return (n == '0) ? REP_W'(16) : {1'b0, n};
    endfunction

endpackage

// File: rtl/contador_tc_sync.sv
// Brings an active-low terminal-count pin into the clk domain and emits one
// registered pulse per falling edge.
module contador_tc_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tc_n_i,
    output logic evt_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic evt_q;

    // Flops reset high so a pin that is already inactive never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            evt_q  <= 1'b0;
        end else begin
            meta_q <= tc_n_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            evt_q  <= prev_q & ~sync_q;
        end
    end

    assign evt_o = evt_q;

endmodule

// File: rtl/contador_seq.sv
// Turns CLEAR/LOAD/UP n/DOWN n commands into ordered 74x193 pin waveforms and
// tracks the expected count. Handshake: a command is taken on a clk edge where
// cmd_valid and cmd_ready are both high; cmd_ready is high only in IDLE.
module contador_seq
    import contador_pkg::*;
#(
    parameter int HALF_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_data,
    output logic             MR,
    output logic             PL,
    output logic             CPU,
    output logic             CPD,
    output logic             P0,
    output logic             P1,
    output logic             P2,
    output logic             P3,
    input  logic             TCU_in,
    input  logic             TCD_in,
    output logic             tcu_evt,
    output logic             tcd_evt,
    output logic [CNT_W-1:0] shadow_q,
    output logic [2:0]       dbg_state
);

    localparam int              PH_W    = $clog2(HALF_W + 1);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_W);

    seq_state_e       state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic             down_q, down_d;
    logic             mr_q, mr_d;
    logic             pl_q, pl_d;
    logic             cpu_q, cpu_d;
    logic             cpd_q, cpd_d;
    logic             ready_q, ready_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            down_q  <= 1'b0;
            mr_q    <= 1'b0;
            pl_q    <= 1'b1;
            cpu_q   <= 1'b1;
            cpd_q   <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            down_q  <= down_d;
            mr_q    <= mr_d;
            pl_q    <= pl_d;
            cpu_q   <= cpu_d;
            cpd_q   <= cpd_d;
            ready_q <= ready_d;
        end
    end

    // Pin values computed here are the ones shown during the next state's cycle.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        down_d  = down_q;
        mr_d    = 1'b0;
        pl_d    = 1'b1;
        cpu_d   = 1'b1;
        cpd_d   = 1'b1;
        ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid && ready_q) begin
                    ready_d = 1'b0;
                    phase_d = PH_ONE;
                    case (op_e'(cmd_op))
                        OP_CLEAR: begin
                            state_d = ST_CLEAR;
                            mr_d    = 1'b1;
                            cnt_d   = '0;
                        end
                        OP_LOAD: begin
                            state_d = ST_LOAD_SETUP;
                            p_d     = cmd_data;
                        end
                        default: begin
                            state_d = ST_PULSE_LO;
                            rep_d   = pulse_count(cmd_data);
                            down_d  = (op_e'(cmd_op) == OP_DOWN);
                            if (op_e'(cmd_op) == OP_DOWN) cpd_d = 1'b0;
                            else                          cpu_d = 1'b0;
                        end
                    endcase
                end
            end

            ST_CLEAR: begin
                if (phase_q == PH_LAST) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    phase_d = phase_q + PH_ONE;
                    mr_d    = 1'b1;
                end
            end

            ST_LOAD_SETUP: begin
                state_d = ST_LOAD_ACT;
                phase_d = PH_ONE;
                pl_d    = 1'b0;
                cnt_d   = p_q;
            end

            ST_LOAD_ACT: begin
                if (phase_q == PH_LAST) begin
                    state_d = ST_LOAD_HOLD;
                end else begin
                    phase_d = phase_q + PH_ONE;
                    pl_d    = 1'b0;
                end
            end

            ST_LOAD_HOLD: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            ST_PULSE_LO: begin
                if (phase_q == PH_LAST) begin
                    state_d = ST_PULSE_HI;
                    phase_d = PH_ONE;
                    cnt_d   = down_q ? (cnt_q - CNT_W'(1)) : (cnt_q + CNT_W'(1));
                end else begin
                    phase_d = phase_q + PH_ONE;
                    if (down_q) cpd_d = 1'b0;
                    else        cpu_d = 1'b0;
                end
            end

            ST_PULSE_HI: begin
                if (phase_q == PH_LAST) begin
                    rep_d = rep_q - REP_W'(1);
                    if (rep_q == REP_W'(1)) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_PULSE_LO;
                        phase_d = PH_ONE;
                        if (down_q) cpd_d = 1'b0;
                        else        cpu_d = 1'b0;
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    contador_tc_sync u_tcu_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .tc_n_i (TCU_in),
        .evt_o  (tcu_evt)
    );

    contador_tc_sync u_tcd_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .tc_n_i (TCD_in),
        .evt_o  (tcd_evt)
    );

    // P0 is the counter's LSB-side input but carries the command MSB.
    assign P0        = p_q[3];
    assign P1        = p_q[2];
    assign P2        = p_q[1];
    assign P3        = p_q[0];
    assign MR        = mr_q;
    assign PL        = pl_q;
    assign CPU       = cpu_q;
    assign CPD       = cpd_q;
    assign cmd_ready = ready_q;
    assign shadow_q  = cnt_q;
    assign dbg_state = state_q;

endmodule
